// File: rtl/dcache_4kb_pkg.sv
// Shared definitions for the 4 KB data store: geometry, index slice and the
// completion record that the LSQ can reuse.
package dcache_4kb_pkg;

    localparam int DC_WORDS    = 1024;
    localparam int DC_IDX_W    = 10;
    localparam int DC_IDX_LO   = 2;
    localparam int DC_IDX_HI   = 11;
    localparam int DC_DATA_W   = 32;
    // Widest tag the completion record carries; narrower tags are zero-extended.
    localparam int DC_ID_MAX_W = 16;

    typedef struct packed {
        logic                   valid;
        logic [DC_ID_MAX_W-1:0] id;
        logic [DC_DATA_W-1:0]   data;
    } dc_cpl_t;

endpackage

// File: rtl/dcache_4kb_if.sv
// Request/completion bus between the LSQ (master) and the data store (slave).
interface dcache_4kb_if #(
    parameter int ID_W = 4
);
    logic            memR;
    logic            memW;
    logic [ID_W-1:0] ldstID;
    logic [31:0]     addr;
    logic [31:0]     Wdata;
    logic [31:0]     Rdata;
    logic [ID_W-1:0] ldstID_out;
    logic            ready_out;

    modport master (
        output memR, memW, ldstID, addr, Wdata,
        input  Rdata, ldstID_out, ready_out
    );

    modport slave (
        input  memR, memW, ldstID, addr, Wdata,
        output Rdata, ldstID_out, ready_out
    );
endinterface

// File: rtl/dcache_4kb_resp_pipe.sv
// LATENCY-stage completion shift register with async clear; the last stage
// holds its payload across bubbles so the outputs keep the last completion.
module dcache_resp_pipe
    import dcache_4kb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  dc_cpl_t i_cpl,
    output dc_cpl_t o_cpl
);
    dc_cpl_t [LATENCY-1:0] r_stage;
    dc_cpl_t [LATENCY:0]   w_chain;

    assign w_chain[0]         = i_cpl;
    assign w_chain[LATENCY:1] = r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_stage[i] <= w_chain[i];
            end
            r_stage[LATENCY-1].valid <= w_chain[LATENCY-1].valid;
            if (w_chain[LATENCY-1].valid) begin
                r_stage[LATENCY-1].id   <= w_chain[LATENCY-1].id;
                r_stage[LATENCY-1].data <= w_chain[LATENCY-1].data;
            end
        end
    end

    assign o_cpl = r_stage[LATENCY-1];

endmodule

// File: rtl/dcache_4kb.sv
// 4 KB always-hit word store behind the LSQ; one request per cycle, tagged
// completion after a fixed LATENCY.
module dcache_4kb
    import dcache_4kb_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    dcache_4kb_if.slave  bus
);
    logic [DC_DATA_W-1:0] r_mem [DC_WORDS];
    logic [DC_WORDS-1:0]  r_vld;

    logic [DC_IDX_W-1:0]  w_idx;
    logic [DC_DATA_W-1:0] w_rd_data;
    dc_cpl_t              w_cpl_in;
    dc_cpl_t              w_cpl_out;
    logic                 w_unused_bits;

    assign w_idx = bus.addr[DC_IDX_HI:DC_IDX_LO];

    // Array contents are not reset; the valid bits mask stale data instead.
    always_ff @(posedge clk) begin
        if (bus.memW && !rst) begin
            r_mem[w_idx] <= bus.Wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (bus.memW) begin
            r_vld[w_idx] <= 1'b1;
        end
    end

    assign w_rd_data = r_vld[w_idx] ? r_mem[w_idx] : '0;

    // A simultaneous read and write is handled as a write and echoes Wdata.
    always_comb begin
        w_cpl_in       = '0;
        w_cpl_in.valid = bus.memR | bus.memW;
        w_cpl_in.id    = DC_ID_MAX_W'(bus.ldstID);
        w_cpl_in.data  = bus.memW ? bus.Wdata : w_rd_data;
    end

    dcache_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_cpl (w_cpl_in),
        .o_cpl (w_cpl_out)
    );

    assign bus.ready_out  = w_cpl_out.valid;
    assign bus.ldstID_out = w_cpl_out.id[ID_W-1:0];
    assign bus.Rdata      = w_cpl_out.data;

    assign w_unused_bits = ^{bus.addr[31:12], bus.addr[1:0], w_cpl_out.id};

endmodule

// File: tb/tb_dcache_4kb.sv
// Directed and randomized bench for dcache_4kb against a word-array reference
// model with a due-cycle completion queue.
module tb_dcache_4kb;
    localparam int ID_W = 16;
    localparam int L    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_4kb_if #(.ID_W(ID_W)) bus ();

    dcache_4kb #(.ID_W(ID_W), .LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int              due;
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } obs_t;

    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    logic [31:0]     ref_mem [int];
    exp_t            pend [$];
    obs_t            obs [$];
    logic [ID_W-1:0] last_id   = '0;
    logic [31:0]     last_data = '0;

    function automatic int widx(logic [31:0] a);
        return int'((a % 32'd4096) / 32'd4);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_rst(bit v);
        rst = v;
        #1;
        if (v) begin
            pend.delete();
            ref_mem.delete();
            last_id   = '0;
            last_data = '0;
            chk("rst_ready", 32'(bus.ready_out), 32'd0);
            chk("rst_id", 32'(bus.ldstID_out), 32'd0);
            chk("rst_data", bus.Rdata, 32'd0);
        end
    endtask

    task automatic tick(bit r, bit w, logic [ID_W-1:0] id, logic [31:0] a, logic [31:0] d);
        bit exp_rdy;
        bus.memR   = r;
        bus.memW   = w;
        bus.ldstID = id;
        bus.addr   = a;
        bus.Wdata  = d;
        @(posedge clk);
        cyc++;
        if (!rst && (r || w)) begin
            exp_t e;
            e.due = cyc + L - 1;
            e.id  = id;
            if (w) begin
                ref_mem[widx(a)] = d;
                e.data = d;
            end else begin
                e.data = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
            end
            pend.push_back(e);
        end
        @(negedge clk);
        exp_rdy = (pend.size() > 0) && (pend[0].due == cyc);
        if (exp_rdy) begin
            last_id   = pend[0].id;
            last_data = pend[0].data;
            void'(pend.pop_front());
        end
        chk("ready", 32'(bus.ready_out), 32'(exp_rdy));
        chk("id", 32'(bus.ldstID_out), 32'(last_id));
        chk("data", bus.Rdata, last_data);
        if (bus.ready_out) obs.push_back('{bus.ldstID_out, bus.Rdata});
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        bus.memR = 1'b0; bus.memW = 1'b0; bus.ldstID = '0; bus.addr = '0; bus.Wdata = '0;
        set_rst(1'b1);
        idle(2);
        set_rst(1'b0);

        // basic write/read
        obs.delete();
        tick(1'b0, 1'b1, 16'd4001, 32'd40, 32'd9000);
        tick(1'b0, 1'b1, 16'd4002, 32'd44, 32'd9001);
        tick(1'b1, 1'b0, 16'd4003, 32'd40, 32'd0);
        tick(1'b1, 1'b0, 16'd4004, 32'd44, 32'd0);
        idle(3);
        chk("basic_count", 32'(obs.size()), 32'd4);
        chk("basic_id0", 32'(obs[0].id), 32'd4001);
        chk("basic_d0", obs[0].data, 32'd9000);
        chk("basic_id1", 32'(obs[1].id), 32'd4002);
        chk("basic_d1", obs[1].data, 32'd9001);
        chk("basic_id2", 32'(obs[2].id), 32'd4003);
        chk("basic_d2", obs[2].data, 32'd9000);
        chk("basic_id3", 32'(obs[3].id), 32'd4004);
        chk("basic_d3", obs[3].data, 32'd9001);

        // unwritten word after reset
        set_rst(1'b1);
        idle(1);
        set_rst(1'b0);
        obs.delete();
        tick(1'b1, 1'b0, 16'd5, 32'd100, 32'd0);
        idle(2);
        chk("unwr_count", 32'(obs.size()), 32'd1);
        chk("unwr_id", 32'(obs[0].id), 32'd5);
        chk("unwr_data", obs[0].data, 32'd0);

        // aliasing and ignored low bits
        obs.delete();
        tick(1'b0, 1'b1, 16'd1, 32'd40, 32'hDEADBEEF);
        tick(1'b1, 1'b0, 16'd2, 32'd4136, 32'd0);
        tick(1'b1, 1'b0, 16'd3, 32'd43, 32'd0);
        idle(2);
        chk("alias_4136", obs[1].data, 32'hDEADBEEF);
        chk("alias_43", obs[2].data, 32'hDEADBEEF);

        // write priority
        obs.delete();
        tick(1'b1, 1'b1, 16'd3, 32'd8, 32'd7);
        tick(1'b1, 1'b0, 16'd4, 32'd8, 32'd0);
        idle(2);
        chk("prio_echo", obs[0].data, 32'd7);
        chk("prio_read", obs[1].data, 32'd7);

        // mid-flight reset drops the in-flight read and clears valid bits
        tick(1'b0, 1'b1, 16'd6, 32'd200, 32'd55);
        idle(2);
        obs.delete();
        tick(1'b1, 1'b0, 16'd9, 32'd8, 32'd0);
        set_rst(1'b1);
        idle(1);
        tick(1'b1, 1'b0, 16'd10, 32'd200, 32'd0);
        set_rst(1'b0);
        idle(3);
        chk("mid_rst_no_pulse", 32'(obs.size()), 32'd0);
        tick(1'b1, 1'b0, 16'd11, 32'd200, 32'd0);
        idle(2);
        chk("mid_rst_id", 32'(obs[0].id), 32'd11);
        chk("mid_rst_data", obs[0].data, 32'd0);

        // bubble: request, idle, request
        obs.delete();
        tick(1'b0, 1'b1, 16'd12, 32'd300, 32'd77);
        idle(1);
        tick(1'b1, 1'b0, 16'd13, 32'd300, 32'd0);
        idle(3);
        chk("bubble_count", 32'(obs.size()), 32'd2);
        chk("bubble_d1", obs[1].data, 32'd77);

        // randomized traffic over a small aliased address window
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 3);
            a   = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if (n == 200) begin
                set_rst(1'b1);
                idle(1);
                set_rst(1'b0);
            end
            case (sel)
                0:       tick(1'b0, 1'b0, '0, a, $urandom());
                1:       tick(1'b0, 1'b1, ID_W'($urandom()), a, $urandom());
                2:       tick(1'b1, 1'b0, ID_W'($urandom()), a, $urandom());
                default: tick(1'b1, 1'b1, ID_W'($urandom()), a, $urandom());
            endcase
        end
        idle(L + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
